// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 CPU front end: phase encoding, operand
// field codes and the default reset vector.
package nic8_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [2:0] SRC_ROM          = 3'd1;
  localparam logic [2:0] DEST_PC          = 3'd7;
  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// 8-bit program counter: async reset to RESET_PC, parallel load, increment.
// Load wins over increment so a taken jump overrides the immediate step.
module pc_counter
  import nic8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] pc_o
);

  logic [7:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// nic8 fetch/exec phase machine: owns PC and IR, steps past inline
// immediates, applies decoder jumps and detects the jump-to-self halt.
module fetch_sequencer
  import nic8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       resetBar,
  input  logic [7:0] romData,
  input  logic       romReady,
  input  logic       doJump,
  input  logic [7:0] dbus,
  output logic [7:0] romAddr,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic       execEnable,
  output logic       fetching,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] fetch_addr_q, fetch_addr_d;
  logic       imm;
  logic       pc_inc, pc_load;
  logic [7:0] pc_w;

  assign imm = (ir_q[2:0] == SRC_ROM);

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    fetch_addr_d = fetch_addr_q;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    execEnable   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (romReady) begin
          ir_d         = romData;
          fetch_addr_d = pc_w;
          pc_inc       = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // An immediate operand must be on the ROM bus before executing.
        if (!imm || romReady) begin
          execEnable = 1'b1;
          if (doJump) begin
            pc_load = 1'b1;
            state_d = (dbus == fetch_addr_q) ? HALT : FETCH;
          end else begin
            pc_inc  = imm;
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q      <= FETCH;
      ir_q         <= 8'h00;
      fetch_addr_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  pc_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_n      (resetBar),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (dbus),
    .pc_o       (pc_w)
  );

  assign pc       = pc_w;
  assign romAddr  = pc_w;
  assign ir       = ir_q;
  assign fetching = (state_q == FETCH);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, corner sequences
// and a randomized instruction-level reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       resetBar;
  logic [7:0] romData;
  logic       romReady;
  logic       doJump;
  logic [7:0] dbus;
  logic [7:0] romAddr, pc, ir;
  logic       execEnable, fetching, halted;

  logic [7:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always_comb romData = rom[romAddr];

  fetch_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .resetBar(resetBar), .romData(romData), .romReady(romReady),
    .doJump(doJump), .dbus(dbus), .romAddr(romAddr), .pc(pc), .ir(ir),
    .execEnable(execEnable), .fetching(fetching), .halted(halted)
  );

  typedef struct {
    logic       rdy;
    logic       jmp;
    logic [7:0] bus;
    logic [7:0] e_pc;
    logic [7:0] e_ir;
    logic       e_ex;
    logic       e_fe;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are sampled mid-cycle.
  task automatic drive(input logic r, input logic j, input logic [7:0] d);
    romReady = r; doJump = j; dbus = d;
    #3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetBar = 1'b0; romReady = 1'b0; doJump = 1'b0; dbus = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    resetBar = 1'b1;
    tick();
  endtask

  // Runs one complete instruction with romReady high in both phases.
  task automatic run_instr(input logic j, input logic [7:0] d);
    drive(1'b1, 1'b0, 8'h00); tick();
    drive(1'b1, j, d);        tick();
  endtask

  vec_t vt [11];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h1A; rom[8'h01] = 8'h21; rom[8'h02] = 8'h5A;
    rom[8'h03] = 8'h39; rom[8'h40] = 8'h02; rom[8'h10] = 8'h3F;
    rom[8'hFF] = 8'h02;

    // ---- reset state ----
    do_reset();
    drive(1'b0, 1'b0, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", ir, 8'h00);
    chk("rst_exec", {7'd0, execEnable}, 8'd0);
    chk("rst_fetch", {7'd0, fetching}, 8'd1);
    chk("rst_halt", {7'd0, halted}, 8'd0);

    // ---- directed table ----
    vt[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 8'h01, 8'h1A, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'h00, 8'h01, 8'h1A, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 8'h77, 8'h02, 8'h21, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 8'h00, 8'h02, 8'h21, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 8'h00, 8'h03, 8'h21, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 8'h40, 8'h04, 8'h39, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 8'h40, 8'h39, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 8'h40, 8'h39, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 8'h41, 8'h02, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 8'h00, 8'h41, 8'h02, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rdy, vt[i].jmp, vt[i].bus);
      chk($sformatf("tbl%0d_pc", i), pc, vt[i].e_pc);
      chk($sformatf("tbl%0d_addr", i), romAddr, vt[i].e_pc);
      chk($sformatf("tbl%0d_ir", i), ir, vt[i].e_ir);
      chk($sformatf("tbl%0d_exec", i), {7'd0, execEnable}, {7'd0, vt[i].e_ex});
      chk($sformatf("tbl%0d_fetch", i), {7'd0, fetching}, {7'd0, vt[i].e_fe});
      tick();
    end

    // ---- wait states: 3 in FETCH, 2 in immediate EXEC -> 7 cycles ----
    do_reset();
    run_instr(1'b0, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 3 || c == 5 || c == 6) drive(1'b0, 1'b0, 8'h00);
      else                            drive(1'b1, 1'b0, 8'h00);
      if (c <= 4) begin
        chk("ws_fetch_pc", pc, 8'h01);
        chk("ws_fetch_ir", ir, 8'h1A);
      end else begin
        chk("ws_exec_pc", pc, 8'h02);
        chk("ws_exec_ir", ir, 8'h21);
      end
      chk("ws_exec", {7'd0, execEnable}, (c == 7) ? 8'd1 : 8'd0);
      tick();
    end
    drive(1'b1, 1'b0, 8'h00);
    chk("ws_done_fetch", {7'd0, fetching}, 8'd1);
    chk("ws_done_pc", pc, 8'h03);

    // ---- halt on jump-to-self ----
    do_reset();
    run_instr(1'b1, 8'h10);
    run_instr(1'b1, 8'h10);
    drive(1'b1, 1'b0, 8'h00);
    chk("halt_flag", {7'd0, halted}, 8'd1);
    chk("halt_pc", pc, 8'h10);
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, c[0], 8'h10);
      chk("halt_exec", {7'd0, execEnable}, 8'd0);
      chk("halt_fetch", {7'd0, fetching}, 8'd0);
      chk("halt_ir", ir, 8'h3F);
      tick();
    end
    do_reset();
    drive(1'b0, 1'b0, 8'h00);
    chk("halt_rst_pc", pc, 8'h00);
    chk("halt_rst_flag", {7'd0, halted}, 8'd0);

    // ---- PC wrap at 8'hFF ----
    run_instr(1'b1, 8'hFF);
    run_instr(1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_fetch", {7'd0, fetching}, 8'd1);

    // ---- async reset during an immediate EXEC wait ----
    do_reset();
    run_instr(1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h00); tick();
    drive(1'b0, 1'b0, 8'h00);
    chk("ar_pre_pc", pc, 8'h02);
    resetBar = 1'b0;
    #1;
    chk("ar_pc", pc, 8'h00);
    chk("ar_ir", ir, 8'h00);
    chk("ar_fetch", {7'd0, fetching}, 8'd1);
    chk("ar_exec", {7'd0, execEnable}, 8'd0);
    @(negedge clk);
    resetBar = 1'b1;
    tick();

    // ---- randomized, instruction-level reference model ----
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    do_reset();
    begin
      logic [7:0] m_pc, m_ir, addr, d;
      logic       is_imm, j, r;
      m_pc = 8'h00; m_ir = 8'h00;
      for (int n = 0; n < 300; n++) begin
        // fetch: random wait cycles, then the opcode is taken
        for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
          drive(1'b0, 1'($urandom), 8'($urandom));
          chk("rnd_fw_addr", romAddr, m_pc);
          chk("rnd_fw_ir", ir, m_ir);
          chk("rnd_fw_exec", {7'd0, execEnable}, 8'd0);
          chk("rnd_fw_fetch", {7'd0, fetching}, 8'd1);
          tick();
        end
        drive(1'b1, 1'($urandom), 8'($urandom));
        chk("rnd_f_addr", romAddr, m_pc);
        chk("rnd_f_halt", {7'd0, halted}, 8'd0);
        tick();
        addr = m_pc;
        m_ir = rom[m_pc];
        m_pc = m_pc + 8'd1;
        is_imm = (m_ir[2:0] == 3'd1);
        if (is_imm) begin
          for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
            drive(1'b0, 1'($urandom), 8'($urandom));
            chk("rnd_ew_pc", pc, m_pc);
            chk("rnd_ew_ir", ir, m_ir);
            chk("rnd_ew_exec", {7'd0, execEnable}, 8'd0);
            tick();
          end
        end
        r = is_imm ? 1'b1 : 1'($urandom);
        j = ($urandom_range(0, 3) == 0);
        d = 8'($urandom);
        if (j && d == addr) d = d ^ 8'h01;
        drive(r, j, d);
        chk("rnd_e_pc", romAddr, m_pc);
        chk("rnd_e_ir", ir, m_ir);
        chk("rnd_e_exec", {7'd0, execEnable}, 8'd1);
        chk("rnd_e_fetch", {7'd0, fetching}, 8'd0);
        tick();
        if (j)           m_pc = d;
        else if (is_imm) m_pc = m_pc + 8'd1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
